// File: rtl/ctrl_pkg.sv
// Shared control-pipeline definitions: opcodes, selector encodings and
// the per-stage control bundles.
package ctrl_pkg;

  localparam int CTRL_OPCODE_W   = 7;
  localparam int CTRL_REG_ADDR_W = 5;
  localparam int CTRL_IMM_SEL_W  = 3;
  localparam int CTRL_ALU_OP_W   = 3;

  localparam logic [CTRL_OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [CTRL_OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [CTRL_OPCODE_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [CTRL_OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [CTRL_OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [CTRL_OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [CTRL_OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [CTRL_OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [CTRL_OPCODE_W-1:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } alu_a_sel_e;

  typedef enum logic [CTRL_IMM_SEL_W-1:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  typedef enum logic [CTRL_ALU_OP_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_REG = 3'd1,
    ALU_IMM = 3'd2,
    ALU_BR  = 3'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    NPC_SEQ  = 2'd0,
    NPC_BR   = 2'd1,
    NPC_JAL  = 2'd2,
    NPC_JALR = 2'd3
  } npc_sel_e;

  // Full bundle held in ID/EX; downstream fields ride along to MEM/WB.
  typedef struct packed {
    logic                       valid;
    alu_a_sel_e                 alu_a_sel;
    logic                       alu_b_sel;
    imm_sel_e                   imm_sel;
    alu_op_e                    alu_op;
    npc_sel_e                   npc_sel;
    logic                       load;
    logic                       store;
    logic                       write;
    logic [CTRL_REG_ADDR_W-1:0] rd;
  } ctrl_ex_t;

  typedef struct packed {
    logic                       valid;
    logic                       load;
    logic                       store;
    logic                       write;
    logic [CTRL_REG_ADDR_W-1:0] rd;
  } ctrl_mem_t;

  typedef struct packed {
    logic                       valid;
    logic                       write;
    logic [CTRL_REG_ADDR_W-1:0] rd;
  } ctrl_wb_t;

  localparam ctrl_ex_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/control_pipeline_if.sv
// Handshake/control bus between ID logic, the control pipeline and the
// datapath. ex_illegal_o exists only when CTRL_ILLEGAL_TRAP_EN is defined.
interface control_pipeline_if #(
  parameter int OPCODE_W   = 7,
  parameter int REG_ADDR_W = 5,
  parameter int IMM_SEL_W  = 3,
  parameter int ALU_OP_W   = 3
);
  logic                  id_valid_i;
  logic [OPCODE_W-1:0]   id_opcode_i;
  logic [REG_ADDR_W-1:0] id_rd_i;
  logic [REG_ADDR_W-1:0] id_rs1_i;
  logic [REG_ADDR_W-1:0] id_rs2_i;
  logic                  flush_i;
  logic                  hold_i;
  logic                  load_use_stall_o;
  logic                  ex_valid_o;
  logic [1:0]            ex_alu_a_sel_o;
  logic                  ex_alu_b_sel_o;
  logic [IMM_SEL_W-1:0]  ex_imm_sel_o;
  logic [ALU_OP_W-1:0]   ex_alu_op_o;
  logic [1:0]            ex_next_pc_sel_o;
  logic [REG_ADDR_W-1:0] ex_rd_o;
  logic                  mem_valid_o;
  logic                  mem_load_o;
  logic                  mem_store_o;
  logic [REG_ADDR_W-1:0] mem_rd_o;
  logic                  wb_valid_o;
  logic                  wb_write_o;
  logic [REG_ADDR_W-1:0] wb_rd_o;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic                  ex_illegal_o;
`endif

  modport master (
    output id_valid_i, id_opcode_i, id_rd_i, id_rs1_i, id_rs2_i, flush_i, hold_i,
    input  load_use_stall_o,
    input  ex_valid_o, ex_alu_a_sel_o, ex_alu_b_sel_o, ex_imm_sel_o, ex_alu_op_o,
    input  ex_next_pc_sel_o, ex_rd_o,
    input  mem_valid_o, mem_load_o, mem_store_o, mem_rd_o,
`ifdef CTRL_ILLEGAL_TRAP_EN
    input  ex_illegal_o,
`endif
    input  wb_valid_o, wb_write_o, wb_rd_o
  );

  modport slave (
    input  id_valid_i, id_opcode_i, id_rd_i, id_rs1_i, id_rs2_i, flush_i, hold_i,
    output load_use_stall_o,
    output ex_valid_o, ex_alu_a_sel_o, ex_alu_b_sel_o, ex_imm_sel_o, ex_alu_op_o,
    output ex_next_pc_sel_o, ex_rd_o,
    output mem_valid_o, mem_load_o, mem_store_o, mem_rd_o,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output ex_illegal_o,
`endif
    output wb_valid_o, wb_write_o, wb_rd_o
  );
endinterface

// File: rtl/control_decode_core.sv
// Combinational RV32I opcode -> control bundle decode. valid is left 0;
// the pipeline qualifies it. Optional illegal_o under CTRL_ILLEGAL_TRAP_EN.
module control_decode_core
  import ctrl_pkg::*;
(
  input  logic [CTRL_OPCODE_W-1:0]   opcode_i,
  input  logic [CTRL_REG_ADDR_W-1:0] rd_i,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic                       illegal_o,
`endif
  output ctrl_ex_t                   bundle_o
);

  // Opcode table; unknown opcodes fall through to the all-zero bundle.
  always_comb begin
    bundle_o = CTRL_BUBBLE;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_o = 1'b0;
`endif
    case (opcode_i)
      OP_R: begin
        bundle_o.alu_op = ALU_REG;
        bundle_o.write  = 1'b1;
      end
      OP_LOAD: begin
        bundle_o.alu_b_sel = 1'b1;
        bundle_o.load      = 1'b1;
        bundle_o.write     = 1'b1;
      end
      OP_IMM: begin
        bundle_o.alu_b_sel = 1'b1;
        bundle_o.alu_op    = ALU_IMM;
        bundle_o.write     = 1'b1;
      end
      OP_JALR: begin
        bundle_o.alu_b_sel = 1'b1;
        bundle_o.npc_sel   = NPC_JALR;
        bundle_o.write     = 1'b1;
      end
      OP_STORE: begin
        bundle_o.alu_b_sel = 1'b1;
        bundle_o.imm_sel   = IMM_S;
        bundle_o.store     = 1'b1;
      end
      OP_BRANCH: begin
        bundle_o.imm_sel = IMM_B;
        bundle_o.alu_op  = ALU_BR;
        bundle_o.npc_sel = NPC_BR;
      end
      OP_AUIPC: begin
        bundle_o.alu_a_sel = A_PC;
        bundle_o.alu_b_sel = 1'b1;
        bundle_o.imm_sel   = IMM_U;
        bundle_o.write     = 1'b1;
      end
      OP_LUI: begin
        bundle_o.alu_a_sel = A_ZERO;
        bundle_o.alu_b_sel = 1'b1;
        bundle_o.imm_sel   = IMM_U;
        bundle_o.write     = 1'b1;
      end
      OP_JAL: begin
        bundle_o.alu_a_sel = A_PC;
        bundle_o.imm_sel   = IMM_J;
        bundle_o.npc_sel   = NPC_JAL;
        bundle_o.write     = 1'b1;
      end
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_o = 1'b1;
`endif
      end
    endcase
    // Non-writing instructions never carry a destination downstream.
    bundle_o.rd = bundle_o.write ? rd_i : '0;
  end

endmodule

// File: rtl/control_pipeline.sv
// ID/EX, EX/MEM, MEM/WB control registers with load-use stall, flush and
// global hold. Optional CTRL_ILLEGAL_TRAP_EN adds a registered ex_illegal_o.
module control_pipeline
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W   = CTRL_OPCODE_W,
  parameter int REG_ADDR_W = CTRL_REG_ADDR_W,
  parameter int IMM_SEL_W  = CTRL_IMM_SEL_W,
  parameter int ALU_OP_W   = CTRL_ALU_OP_W
) (
  input logic               clk,
  input logic               rst_n,
  control_pipeline_if.slave bus
);

  logic                  id_valid, flush, hold;
  logic [OPCODE_W-1:0]   id_op;
  logic [REG_ADDR_W-1:0] id_rd, id_rs1, id_rs2;

  assign id_valid = bus.id_valid_i;
  assign id_op    = bus.id_opcode_i;
  assign id_rd    = bus.id_rd_i;
  assign id_rs1   = bus.id_rs1_i;
  assign id_rs2   = bus.id_rs2_i;
  assign flush    = bus.flush_i;
  assign hold     = bus.hold_i;

  ctrl_ex_t  id_bundle, idex_d, idex_q;
  ctrl_mem_t exmem_d, exmem_q;
  ctrl_wb_t  memwb_d, memwb_q;
  logic      uses_rs2, load_use;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic id_illegal, ex_illegal_d, ex_illegal_q;
`endif

  control_decode_core u_dec (
    .opcode_i (id_op),
    .rd_i     (id_rd),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .illegal_o(id_illegal),
`endif
    .bundle_o (id_bundle)
  );

  // Load-use hazard: load in EX writing a register the ID instruction reads.
  // rs2 only counts for the formats that actually read it.
  always_comb begin
    uses_rs2 = (id_op == OP_R) || (id_op == OP_STORE) || (id_op == OP_BRANCH);
    load_use = idex_q.valid && idex_q.load && (idex_q.rd != '0) && id_valid &&
               ((idex_q.rd == id_rs1) || ((idex_q.rd == id_rs2) && uses_rs2));
  end

  // Priority mux: hold freezes all; flush/stall/invalid inject a bubble.
  always_comb begin
    idex_d  = idex_q;
    exmem_d = exmem_q;
    memwb_d = memwb_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
    ex_illegal_d = ex_illegal_q;
`endif
    if (!hold) begin
      if (flush || load_use || !id_valid) begin
        idex_d = CTRL_BUBBLE;
`ifdef CTRL_ILLEGAL_TRAP_EN
        ex_illegal_d = 1'b0;
`endif
      end else begin
        idex_d       = id_bundle;
        idex_d.valid = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
        ex_illegal_d = id_illegal;
`endif
      end
      exmem_d.valid = idex_q.valid;
      exmem_d.load  = idex_q.load;
      exmem_d.store = idex_q.store;
      exmem_d.write = idex_q.write;
      exmem_d.rd    = idex_q.rd;
      memwb_d.valid = exmem_q.valid;
      memwb_d.write = exmem_q.write;
      memwb_d.rd    = exmem_q.rd;
    end
  end

  // Stage registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_q  <= CTRL_BUBBLE;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  // Illegal flag travels with the ID/EX bundle.
  always_ff @(posedge clk) begin
    if (!rst_n) ex_illegal_q <= 1'b0;
    else        ex_illegal_q <= ex_illegal_d;
  end
  assign bus.ex_illegal_o = ex_illegal_q;
`endif

  assign bus.load_use_stall_o = load_use && !hold;
  assign bus.ex_valid_o       = idex_q.valid;
  assign bus.ex_alu_a_sel_o   = idex_q.alu_a_sel;
  assign bus.ex_alu_b_sel_o   = idex_q.alu_b_sel;
  assign bus.ex_imm_sel_o     = IMM_SEL_W'(idex_q.imm_sel);
  assign bus.ex_alu_op_o      = ALU_OP_W'(idex_q.alu_op);
  assign bus.ex_next_pc_sel_o = idex_q.npc_sel;
  assign bus.ex_rd_o          = idex_q.rd;
  assign bus.mem_valid_o      = exmem_q.valid;
  assign bus.mem_load_o       = exmem_q.load;
  assign bus.mem_store_o      = exmem_q.store;
  assign bus.mem_rd_o         = exmem_q.rd;
  assign bus.wb_valid_o       = memwb_q.valid;
  assign bus.wb_write_o       = memwb_q.write;
  assign bus.wb_rd_o          = memwb_q.rd;

endmodule

// File: tb/tb_control_pipeline.sv
// Self-checking bench for control_pipeline: instruction-level reference
// model compared every cycle, directed scenarios with literal expectations,
// then randomized traffic.
`timescale 1ns/1ps
module tb_control_pipeline;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  control_pipeline_if bus ();
  control_pipeline dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  localparam bit [6:0] R   = 7'b0110011, LW  = 7'b0000011, ADDI = 7'b0010011;
  localparam bit [6:0] JLR = 7'b1100111, SW  = 7'b0100011, BR   = 7'b1100011;
  localparam bit [6:0] AUI = 7'b0010111, LUI = 7'b0110111, JAL  = 7'b1101111;
  localparam bit [6:0] BAD = 7'b1111111;

  bit [6:0] ops [10] = '{R, LW, ADDI, JLR, SW, BR, AUI, LUI, JAL, BAD};

  typedef struct {
    bit v;
    int a, b, imm, op, npc;
    bit ld, st, wr;
    int rd;
    bit ill;
  } ent_t;

  ent_t m_ex, m_mem, m_wb;
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;

  function automatic ent_t zero_ent();
    ent_t e;
    e.v = 0; e.a = 0; e.b = 0; e.imm = 0; e.op = 0; e.npc = 0;
    e.ld = 0; e.st = 0; e.wr = 0; e.rd = 0; e.ill = 0;
    return e;
  endfunction

  // Reference decode table for a valid ID instruction.
  function automatic ent_t dec(bit [6:0] op, int rd);
    ent_t e = zero_ent();
    e.v = 1;
    case (op)
      R:    begin e.op = 1; e.wr = 1; end
      LW:   begin e.b = 1; e.ld = 1; e.wr = 1; end
      ADDI: begin e.b = 1; e.op = 2; e.wr = 1; end
      JLR:  begin e.b = 1; e.npc = 3; e.wr = 1; end
      SW:   begin e.b = 1; e.imm = 1; e.st = 1; end
      BR:   begin e.imm = 2; e.op = 3; e.npc = 1; end
      AUI:  begin e.a = 1; e.b = 1; e.imm = 3; e.wr = 1; end
      LUI:  begin e.a = 2; e.b = 1; e.imm = 3; e.wr = 1; end
      JAL:  begin e.a = 1; e.imm = 4; e.npc = 2; e.wr = 1; end
      default: e.ill = 1;
    endcase
    e.rd = e.wr ? rd : 0;
    return e;
  endfunction

  function automatic bit exp_stall();
    bit rs2u = (bus.id_opcode_i == R) || (bus.id_opcode_i == SW) || (bus.id_opcode_i == BR);
    return !bus.hold_i && m_ex.v && m_ex.ld && (m_ex.rd != 0) && bus.id_valid_i &&
           ((m_ex.rd == int'(bus.id_rs1_i)) || ((m_ex.rd == int'(bus.id_rs2_i)) && rs2u));
  endfunction

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Model advances one instruction slot per unheld edge.
  always @(posedge clk) begin
    bit st;
    st = exp_stall();
    if (!rst_n) begin
      m_ex = zero_ent(); m_mem = zero_ent(); m_wb = zero_ent();
    end else if (!bus.hold_i) begin
      m_wb  = m_mem;
      m_mem = m_ex;
      if (bus.flush_i || st || !bus.id_valid_i) m_ex = zero_ent();
      else m_ex = dec(bus.id_opcode_i, int'(bus.id_rd_i));
    end
  end

  // Every-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall",     int'(bus.load_use_stall_o), int'(exp_stall()));
      check("ex_valid",  int'(bus.ex_valid_o),       int'(m_ex.v));
      check("ex_a_sel",  int'(bus.ex_alu_a_sel_o),   m_ex.a);
      check("ex_b_sel",  int'(bus.ex_alu_b_sel_o),   m_ex.b);
      check("ex_imm",    int'(bus.ex_imm_sel_o),     m_ex.imm);
      check("ex_op",     int'(bus.ex_alu_op_o),      m_ex.op);
      check("ex_npc",    int'(bus.ex_next_pc_sel_o), m_ex.npc);
      check("ex_rd",     int'(bus.ex_rd_o),          m_ex.rd);
`ifdef CTRL_ILLEGAL_TRAP_EN
      check("ex_illegal", int'(bus.ex_illegal_o),    int'(m_ex.ill));
`endif
      check("mem_valid", int'(bus.mem_valid_o),      int'(m_mem.v));
      check("mem_load",  int'(bus.mem_load_o),       int'(m_mem.ld));
      check("mem_store", int'(bus.mem_store_o),      int'(m_mem.st));
      check("mem_rd",    int'(bus.mem_rd_o),         m_mem.rd);
      check("wb_valid",  int'(bus.wb_valid_o),       int'(m_wb.v));
      check("wb_write",  int'(bus.wb_write_o),       int'(m_wb.wr));
      check("wb_rd",     int'(bus.wb_rd_o),          m_wb.rd);
    end
  end

  // Present one ID slot; st returns the stall seen during that cycle.
  // Returns 2ns after the edge that registered the slot.
  task automatic cyc(input bit v, input bit [6:0] op, input int rd, input int rs1,
                     input int rs2, input bit fl, input bit hd, output bit st);
    bus.id_valid_i  = v;
    bus.id_opcode_i = op;
    bus.id_rd_i     = rd[4:0];
    bus.id_rs1_i    = rs1[4:0];
    bus.id_rs2_i    = rs2[4:0];
    bus.flush_i     = fl;
    bus.hold_i      = hd;
    @(negedge clk);
    st = bus.load_use_stall_o;
    @(posedge clk);
    #2;
  endtask

  initial begin
    bit st;
    bus.id_valid_i = 0; bus.id_opcode_i = '0; bus.id_rd_i = '0;
    bus.id_rs1_i = '0; bus.id_rs2_i = '0; bus.flush_i = 0; bus.hold_i = 0;
    @(posedge clk); #2;
    chk_en = 1'b1;

    // Reset with a valid R instruction presented
    rst_n = 0;
    cyc(1, R, 3, 1, 2, 0, 0, st);
    cyc(1, R, 3, 1, 2, 0, 0, st);
    check("rst_ex_valid", int'(bus.ex_valid_o), 0);
    check("rst_mem_valid", int'(bus.mem_valid_o), 0);
    check("rst_wb_write", int'(bus.wb_write_o), 0);
    check("rst_stall", int'(st), 0);
    rst_n = 1;
    cyc(1, R, 3, 1, 2, 0, 0, st);
    check("rel_ex_valid", int'(bus.ex_valid_o), 1);
    check("rel_ex_op", int'(bus.ex_alu_op_o), 1);
    cyc(0, R, 0, 0, 0, 0, 0, st);
    cyc(0, R, 0, 0, 0, 0, 0, st);
    check("rel_wb_write", int'(bus.wb_write_o), 1);
    check("rel_wb_rd", int'(bus.wb_rd_o), 3);

    // Load-use on rs1
    cyc(1, LW, 5, 0, 0, 0, 0, st);
    cyc(1, ADDI, 6, 5, 0, 0, 0, st);
    check("lu_stall", int'(st), 1);
    check("lu_bubble", int'(bus.ex_valid_o), 0);
    check("lu_mem_load", int'(bus.mem_load_o), 1);
    cyc(1, ADDI, 6, 5, 0, 0, 0, st);
    check("lu_retry_stall", int'(st), 0);
    check("lu_retry_op", int'(bus.ex_alu_op_o), 2);
    check("lu_retry_rd", int'(bus.ex_rd_o), 6);
    cyc(1, LW, 0, 0, 0, 0, 0, st);
    cyc(1, ADDI, 6, 0, 0, 0, 0, st);
    check("lu_rd0", int'(st), 0);

    // rs2 qualification
    cyc(1, LW, 7, 0, 0, 0, 0, st);
    cyc(1, ADDI, 8, 1, 7, 0, 0, st);
    check("rs2_addi", int'(st), 0);
    cyc(1, LW, 7, 0, 0, 0, 0, st);
    cyc(1, SW, 0, 1, 7, 0, 0, st);
    check("rs2_sw", int'(st), 1);
    cyc(1, SW, 0, 1, 7, 0, 0, st);
    check("rs2_sw_retry", int'(st), 0);

    // Flush beats load-use
    cyc(1, LW, 9, 0, 0, 0, 0, st);
    cyc(1, ADDI, 1, 9, 0, 1, 0, st);
    check("fl_stall_out", int'(st), 1);
    check("fl_ex_valid", int'(bus.ex_valid_o), 0);
    check("fl_mem_load", int'(bus.mem_load_o), 1);
    check("fl_mem_rd", int'(bus.mem_rd_o), 9);

    // Hold freezes everything and gates the stall
    cyc(1, JAL, 1, 0, 0, 0, 0, st);
    cyc(1, LUI, 2, 0, 0, 0, 0, st);
    cyc(1, LW, 4, 0, 0, 0, 0, st);
    for (int i = 0; i < 3; i++) begin
      cyc(1, ADDI, 5, 4, 0, 0, 1, st);
      check("hold_stall", int'(st), 0);
      check("hold_ex_rd", int'(bus.ex_rd_o), 4);
      check("hold_mem_rd", int'(bus.mem_rd_o), 2);
      check("hold_wb_rd", int'(bus.wb_rd_o), 1);
    end
    cyc(1, SW, 0, 4, 4, 0, 0, st);
    check("hold_resume_stall", int'(st), 1);
    check("hold_resume_mem_rd", int'(bus.mem_rd_o), 4);
    check("hold_resume_wb_rd", int'(bus.wb_rd_o), 2);
    cyc(1, SW, 0, 4, 4, 0, 0, st);
    check("hold_sw_imm", int'(bus.ex_imm_sel_o), 1);
    cyc(0, R, 0, 0, 0, 0, 0, st);
    check("hold_sw_store", int'(bus.mem_store_o), 1);

    // Reset mid-stall drops the stall
    cyc(1, LW, 5, 0, 0, 0, 0, st);
    rst_n = 0;
    cyc(1, ADDI, 1, 5, 0, 0, 0, st);
    check("rst_mid_stall_before", int'(st), 1);
    rst_n = 1;
    cyc(1, ADDI, 1, 5, 0, 0, 0, st);
    check("rst_mid_stall_after", int'(st), 0);

    // Decode sweep (model checks each bundle) plus pinned literals
    foreach (ops[i]) cyc(1, ops[i], 1, 0, 0, 0, 0, st);
    cyc(1, JLR, 2, 0, 0, 0, 0, st);
    check("dec_jalr_npc", int'(bus.ex_next_pc_sel_o), 3);
    cyc(1, AUI, 2, 0, 0, 0, 0, st);
    check("dec_auipc_a", int'(bus.ex_alu_a_sel_o), 1);
    check("dec_auipc_imm", int'(bus.ex_imm_sel_o), 3);
    cyc(1, BR, 5, 0, 0, 0, 0, st);
    check("dec_br_rd0", int'(bus.ex_rd_o), 0);
    check("dec_br_op", int'(bus.ex_alu_op_o), 3);
    cyc(1, BAD, 5, 0, 0, 0, 0, st);
    check("dec_bad_valid", int'(bus.ex_valid_o), 1);
    check("dec_bad_b", int'(bus.ex_alu_b_sel_o), 0);
    check("dec_bad_rd", int'(bus.ex_rd_o), 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("dec_bad_illegal", int'(bus.ex_illegal_o), 1);
`endif

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      bit [6:0] op;
      op = ops[$urandom_range(0, 9)];
      rst_n = ($urandom_range(0, 99) != 0);
      cyc($urandom_range(0, 9) < 8, op, $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 7), $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0, st);
    end
    rst_n = 1;
    cyc(0, R, 0, 0, 0, 0, 0, st);
    cyc(0, R, 0, 0, 0, 0, 0, st);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_pipeline.md
Name: control_pipeline

Overview:
- Parametrised successor to the combinational control decoder.
- Decodes the raw RV32I opcode in ID and carries the control bundle through registered ID/EX, EX/MEM and MEM/WB stages.
- Applies load-use stall, branch/jump flush and a global pipeline hold inside the block.
- Sits between the instruction-decode logic and the datapath; the datapath consumes the per-stage control outputs directly.

Parameters:
- OPCODE_W, 7, opcode field width.
- REG_ADDR_W, 5, register-address width (rd/rs1/rs2).
- IMM_SEL_W, 3, immediate-selector width (I/S/B/U/J).
- ALU_OP_W, 3, ALU-operation-class width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- id_valid_i  in  1  ID holds a real instruction.
- id_opcode_i  in  OPCODE_W  instruction[6:0].
- id_rd_i / id_rs1_i / id_rs2_i  in  REG_ADDR_W  register fields of the ID instruction.
- flush_i  in  1  taken branch or jump resolved in EX; kill ID.
- hold_i  in  1  freeze every stage (memory wait).
- load_use_stall_o  in/out: out  1  freeze PC and IF/ID this cycle.
- ex_valid_o, ex_alu_a_sel_o[1:0], ex_alu_b_sel_o, ex_imm_sel_o[IMM_SEL_W], ex_alu_op_o[ALU_OP_W], ex_next_pc_sel_o[1:0], ex_rd_o[REG_ADDR_W]  out  EX-stage controls.
- mem_valid_o, mem_load_o, mem_store_o, mem_rd_o[REG_ADDR_W]  out  MEM-stage controls.
- wb_valid_o, wb_write_o, wb_rd_o[REG_ADDR_W]  out  WB-stage controls.

Behaviour:
- Decode in ID (combinational, opcode → bundle):
  - R 0110011: a=rs1(0), b=rs2(0), op=1, write.
  - lw 0000011: a=0, b=imm(1), imm=I(0), op=0, load, write.
  - addi 0010011: b=1, imm=I, op=2, write.
  - jalr 1100111: b=1, imm=I, op=0, npc=3, write.
  - sw 0100011: b=1, imm=S(1), op=0, store.
  - branch 1100011: b=0, imm=B(2), op=3, npc=1.
  - auipc 0010111: a=pc(1), b=1, imm=U(3), op=0, write.
  - lui 0110111: a=zero(2), b=1, imm=U, op=0, write.
  - jal 1101111: a=pc, imm=J(4), op=0, npc=2, write.
  - Any other opcode → all-zero bundle (NOP).
- rd forced to 0 in the bundle when write=0.
- Latency: an ID instruction appears on ex_* one cycle later, mem_* two cycles later, wb_* three cycles later.
- Load-use stall:
  - Condition: load_use_stall_o = ex_valid & ex_load & ex_rd≠0 & id_valid & (ex_rd==id_rs1 | (ex_rd==id_rs2 & ID opcode ∈ {R, sw, branch})).
  - This is combinational from ID inputs and registered EX state.
  - On stall, the ID/EX register loads a bubble; the ID instruction re-presents next cycle.
- Flush: ID/EX loads a bubble regardless of the ID instruction; EX/MEM advances normally.
- Priority, highest first:
  - rst_n low: all valid and control registers clear next edge.
  - hold_i: all three stage registers keep their value.
  - flush_i: bubble into ID/EX.
  - load-use stall: bubble into ID/EX.
  - Otherwise: normal advance.
- load_use_stall_o is gated low while hold_i=1.
- Bubble definition: valid=0 and every control bit 0. A bubble never asserts write, load or store downstream.
- Reset: every output is 0, including load_use_stall_o. A reset mid-stall drops the stall on the next cycle.
- Simultaneous flush and load-use: the flush wins, and load_use_stall_o is still driven. IF logic must treat flush as dominant.
- Valid gating: an instruction with id_valid_i=0 enters ID/EX as a bubble.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- With the macro defined:
  - Adds output ex_illegal_o (1 bit).
  - ex_illegal_o is registered alongside ID/EX: 1 for a valid instruction whose opcode is outside the nine decoded classes.
  - Bundle is still NOP; flush, hold and stall apply to ex_illegal_o identically.
- Without the macro: the port is absent and unknown opcodes are silently NOPs.

Decomposition:
- Package ctrl_pkg:
  - Opcode localparams.
  - Selector encodings as enums: alu_a_sel_e, imm_sel_e, alu_op_e, npc_sel_e.
  - Packed structs ctrl_ex_t, ctrl_mem_t, ctrl_wb_t.
  - Constant CTRL_BUBBLE.
- One sub-module, control_decode_core: purely combinational opcode→bundle decode.
- control_pipeline contains the three stage registers, hazard logic and priority mux.

Test Plan:
- Reset: rst_n=0 for 2 cycles with id_opcode_i=0110011, id_valid_i=1 → all outputs 0. After release, ex_valid_o=1 and ex_alu_op_o=1 one cycle later; wb_write_o=1 three cycles later.
- Load-use: lw rd=5, then addi rs1=5 → load_use_stall_o=1 for exactly one cycle; one bubble in EX; addi reaches ex_* one cycle late. Repeat with rd=0 → no stall.
- rs2 qualification: lw rd=7, then addi with rs2 field=7 → no stall. lw rd=7, then sw rs2=7 → stall.
- Flush priority: flush_i=1 together with a load-use condition → ex_valid_o=0 next cycle; lw continues to mem_load_o=1.
- Hold: a sequence of jal/lui/sw with hold_i=1 for 3 cycles → all stage outputs frozen and load_use_stall_o=0; the sequence resumes intact afterwards.
- Decode sweep: all nine opcodes plus 1111111 → each EX/MEM/WB bundle matches the decode list above. With CTRL_ILLEGAL_TRAP_EN defined, 1111111 gives ex_illegal_o=1.
